// File: rtl/counter_pkg.sv
// counter_pkg: register map, config bit positions and shared types for counter_core
package counter_pkg;
  localparam int REG_COUNT  = 0;
  localparam int REG_CONFIG = 1;
  localparam int REG_STATUS = 2;
  localparam int REG_IRQ    = 3;
  localparam int CFG_EN     = 0;
  localparam int CFG_DIR    = 1;
  localparam int CFG_INTEN  = 2;
  typedef logic [3:0] regs_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/counter_if.sv
// counter_if: strobe/data bundle between the bus adapter (master) and counter_core (slave)
interface counter_if;
  import counter_pkg::*;
  regs_t write_en;
  regs_t read_en;
  word_t data_in;
  word_t [3:0] data_out;
  logic irq_out;
  modport master(output write_en, read_en, data_in, input data_out, irq_out);
  modport slave(input write_en, read_en, data_in, output data_out, irq_out);
endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles by PRESCALE into single-cycle ticks
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    tick = enable & ~clear & (cnt_q == LAST);
    cnt_d = (clear | tick) ? '0 : enable ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/counter_core.sv
// counter_core: register file with prescaled 32-bit up/down counter and wrap interrupt
module counter_core import counter_pkg::*; #(
  parameter int PRESCALE = 1,
  parameter int unsigned THRESHOLD = 1000
) (
  input logic clk,
  input logic reset,
  counter_if.slave bus
);
  word_t count_q, count_d;
  logic [2:0] cfg_q, cfg_d;
  logic pend_q, pend_d, tick, wrap, unused_rd;
  // a counter write also clears the prescaler, so the tick of that cycle is dropped
  counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk),
    .reset(reset),
    .enable(cfg_q[CFG_EN]),
    .clear(bus.write_en[REG_COUNT]),
    .tick(tick)
  );
  always_comb begin
    wrap = tick & (cfg_q[CFG_DIR] ? &count_q : ~|count_q);
    count_d = bus.write_en[REG_COUNT] ? bus.data_in
            : tick ? (cfg_q[CFG_DIR] ? count_q + 32'd1 : count_q - 32'd1) : count_q;
    cfg_d = bus.write_en[REG_CONFIG] ? bus.data_in[2:0] : cfg_q;
    pend_d = wrap | (pend_q & ~(bus.write_en[REG_IRQ] & bus.data_in[0]));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count_q <= '0;
      cfg_q <= '0;
      pend_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cfg_q <= cfg_d;
      pend_q <= pend_d;
    end
  assign bus.data_out[REG_COUNT] = count_q;
  assign bus.data_out[REG_CONFIG] = {29'd0, cfg_q};
  assign bus.data_out[REG_STATUS] = {31'd0, count_q < word_t'(THRESHOLD)};
  assign bus.data_out[REG_IRQ] = {31'd0, pend_q};
  assign bus.irq_out = pend_q & cfg_q[CFG_INTEN];
  assign unused_rd = ^bus.read_en;
endmodule
